// File: rtl/rr_decode_arbiter.sv
// -----------------------------------------------------------------------------
// rr_decode_arbiter
//
// Four-requester round-robin arbiter with a one-hot grant decoded from a
// registered owner index. A grant lasts until the owner signals done, drops
// its request, or holds the resource for MAX_HOLD cycles. A hold-limit
// revocation is flagged with a one-cycle timeout pulse. After every grant
// the arbiter spends at least one cycle idle, and the search for the next
// owner starts just past the previous one.
//
// Parameters
//   MAX_HOLD  maximum number of cycles a single grant may last (2..255)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req[3:0]  request lines, req[i] belongs to requester i
//   done      owner releases the resource (looked at only while busy)
//   gnt[3:0]  one-hot grant, zero when no grant is active
//   gnt_idx   index of the current owner, or of the last owner while idle
//   busy      a grant is active
//   timeout   one-cycle pulse on the first idle cycle after a hold-limit
//             revocation
// -----------------------------------------------------------------------------
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Last value the hold counter reaches before the grant is revoked.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state,    state_nxt;
    logic [1:0] ptr,      ptr_nxt;
    logic [1:0] idx_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic       timeout_nxt;
    logic [3:0] gnt_nxt;

    logic [1:0] pick;
    logic       pick_valid;
    logic       release_req;
    logic       at_limit;

    // Round-robin search: walk the candidates from farthest (ptr+3) to
    // nearest (ptr), so the nearest set request overwrites the others.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path leaves it unassigned and no latch appears.
        pick       = ptr;
        pick_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                pick       = ptr + 2'(k);
                pick_valid = 1'b1;
            end
        end
    end

    assign release_req = done | ~req[gnt_idx];
    assign at_limit    = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = BUSY;
                    idx_nxt   = pick;
                    hold_nxt  = 8'd0;
                end
            end
            BUSY: begin
                if (release_req || at_limit) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_idx + 2'd1;
                    // Flag only revocations the owner did not ask for.
                    timeout_nxt = at_limit & ~release_req;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The grant is decoded ahead of the register so gnt comes straight
        // from flops and cannot glitch while gnt_idx and busy change.
        gnt_nxt = (state_nxt == BUSY) ? (4'd1 << idx_nxt) : 4'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt_idx  <= 2'd0;
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
            gnt      <= 4'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt_idx  <= idx_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
            gnt      <= gnt_nxt;
        end
    end

    assign busy = (state == BUSY);

endmodule
